load_store_unit_d: RTL and testbench
====================================

// Module: load_store_unit_d
// PURPOSE
//  MEM-stage load/store front end, directly upstream of the data-side memory management unit.
//  - Turns RV32I load/store requests (funct3, byte address, store data) into word-aligned MMU
//    accesses with byte lanes.
//  - Holds the request stable while the MMU reports a cache miss (nostall low).
//  - Extracts and sign- or zero-extends load data for writeback.
// PARAMETERS
//  AW        32   byte-address width
//  DW        32   data width (fixed; byte-lane logic assumes 4 lanes)
// PORTS
//  clk            in   1   clock; all state changes on the rising edge
//  reset          in   1   asynchronous, active-high
//  req_valid      in   1   pipeline presents a memory request this cycle
//  req_is_store   in   1   1 = store, 0 = load
//  req_funct3     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr       in   AW  byte address
//  req_wdata      in   DW  store data, right-justified
//  pipe_stall     out  1   pipeline must hold; req_* not accepted this cycle
//  ld_valid       out  1   one-cycle pulse: ld_data is valid
//  ld_data        out  DW  extended load result
//  mmu_addy       out  AW  {addr[AW-1:2],2'b00}
//  mmu_datain     out  DW  lane-replicated store data
//  mmu_wen        out  1   store access
//  mmu_ren        out  1   load access
//  mmu_byte_sel   out  4   active byte lanes
//  mmu_nostall    in   1   MMU completes the access this cycle when high
//  mmu_dataout    in   DW  MMU read word, sampled when mmu_nostall is high
//  misalign       out  1   only with MISALIGN_TRAP_EN; one-cycle pulse
//  misalign_addr  out  AW  only with MISALIGN_TRAP_EN; offending address
// BEHAVIOUR
//  Reset:
//  - All outputs 0; state IDLE.
//  - Reset mid-access discards the pending request; no ld_valid is produced for it.
//  FSM: IDLE, ACCESS.
//  - IDLE: legal req_valid at posedge -> latch request, go to ACCESS.
//  - ACCESS: mmu_* driven from the latched registers, held stable.
//    - mmu_nostall high at posedge: access completes.
//      - If req_valid is also high, the next request is latched and the FSM stays in ACCESS
//        (back-to-back, zero bubbles).
//      - Otherwise go to IDLE.
//    - mmu_nostall low: remain in ACCESS, outputs unchanged.
//  Handshake outputs:
//  - pipe_stall = (state==ACCESS) && !mmu_nostall (combinational).
//  - mmu_wen / mmu_ren are 0 in IDLE.
//  Loads:
//  - ld_data is registered at the completing edge; ld_valid pulses the following cycle.
//  - Latency = 1 cycle after completion (2 cycles after acceptance on a hit).
//  - Stores never assert ld_valid.
//  Lanes:
//  - B/BU: sel = 4'b0001 << addr[1:0].
//  - H/HU: sel = 4'b0011 << {addr[1],1'b0}.
//  - W: sel = 4'b1111.
//  Store data:
//  - SB: {4{wdata[7:0]}}.
//  - SH: {2{wdata[15:0]}}.
//  - SW: wdata.
//  Load extract:
//  - word >> (8*addr[1:0]), then the low byte or half is sign-extended (B, H) or
//    zero-extended (BU, HU).
//  Illegal funct3 (011, 110, 111, or 100/101 with store):
//  - Request consumed with no MMU access, no stall, no ld_valid.
//  Misaligned: H with addr[0]=1, or W with addr[1:0]!=0.
//  Simultaneous reset and req_valid: reset wins.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//  - Misaligned request is not issued; FSM stays or returns to IDLE.
//  - misalign pulses 1 cycle after acceptance; misalign_addr is latched.
//  MISALIGN_TRAP_EN undefined:
//  - Ports absent; low address bits are forced aligned (H: addr[0]=0, W: addr[1:0]=0)
//    and the access proceeds normally.
// TESTING
//  1. LW 0x100, MMU nostall=1, dataout=0xDEADBEEF
//     -> mmu_ren=1, sel=1111; ld_valid 1 cycle later, ld_data=0xDEADBEEF; pipe_stall never high.
//  2. LB 0x103, dataout=0x80FF0000 -> sel=1000, ld_data=0xFFFFFF80.
//     Same access as LBU -> ld_data=0x00000080.
//  3. SH 0x102, wdata=0x1234ABCD -> mmu_wen=1, sel=1100, mmu_datain=0xABCDABCD,
//     mmu_addy=0x100; no ld_valid.
//  4. LW with nostall low for 5 cycles -> pipe_stall high 5 cycles, mmu_* stable;
//     ld_valid 1 cycle after nostall rises. Back-to-back SW accepted on the completing edge.
//  5. Reset asserted while stalled in ACCESS
//     -> all outputs 0 immediately; no ld_valid after release.
//  6. LH 0x101: with MISALIGN_TRAP_EN -> misalign pulse, misalign_addr=0x101, no MMU access.
//     Without it -> sel=0011, mmu_addy=0x100, normal load.

Source files
------------

// File: rtl/load_store_unit_d.sv
// load_store_unit_d: RV32I load/store front end to the data MMU; MISALIGN_TRAP_EN adds a misaligned-access trap.
// Latency: access issued the cycle after acceptance; ld_valid pulses one cycle after the completing edge.
// Backpressure: pipe_stall while an access is outstanding and mmu_nostall is low; next request rides the completing edge.
module load_store_unit_d #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_is_store,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          pipe_stall,
  output logic          ld_valid,
  output logic [DW-1:0] ld_data,
  output logic [AW-1:0] mmu_addy,
  output logic [DW-1:0] mmu_datain,
  output logic          mmu_wen,
  output logic          mmu_ren,
  output logic [3:0]    mmu_byte_sel,
  input  logic          mmu_nostall,
  input  logic [DW-1:0] mmu_dataout
`ifdef MISALIGN_TRAP_EN
  ,
  output logic          misalign,
  output logic [AW-1:0] misalign_addr
`endif
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    sel;
    logic [2:0]    funct3;
    logic [1:0]    off;
    logic          wen;
    logic          ren;
  } req_t;

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic          ld_valid_q, ld_valid_d;
  logic [DW-1:0] ld_data_q, ld_data_d;
  logic          f3_legal, is_half, is_word, complete, accept, issue;
  logic [1:0]    off;
  logic [3:0]    sel;
  logic [DW-1:0] wrep, shifted;

  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_is_store;
      default:                f3_legal = 1'b0;
    endcase
    is_half = (req_funct3[1:0] == 2'b01);
    is_word = (req_funct3[1:0] == 2'b10);
    // Without the trap, misaligned halves/words are silently forced to natural alignment.
    if (is_word)      off = 2'b00;
    else if (is_half) off = {req_addr[1], 1'b0};
    else              off = req_addr[1:0];
    if (is_word)      sel = 4'b1111;
    else if (is_half) sel = 4'b0011 << off;
    else              sel = 4'b0001 << off;
    if (is_word)      wrep = req_wdata;
    else if (is_half) wrep = {2{req_wdata[15:0]}};
    else              wrep = {4{req_wdata[7:0]}};
  end

  assign complete = (state_q == ACCESS) && mmu_nostall;
  assign accept   = req_valid && ((state_q == IDLE) || mmu_nostall);

`ifdef MISALIGN_TRAP_EN
  logic          mis, misalign_q, misalign_d;
  logic [AW-1:0] misalign_addr_q, misalign_addr_d;

  assign mis             = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  assign issue           = accept && f3_legal && !mis;
  assign misalign_d      = accept && f3_legal && mis;
  assign misalign_addr_d = misalign_d ? req_addr : misalign_addr_q;
  assign misalign        = misalign_q;
  assign misalign_addr   = misalign_addr_q;
`else
  assign issue = accept && f3_legal;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    if (complete) begin
      state_d   = IDLE;
      req_d.wen = 1'b0;
      req_d.ren = 1'b0;
    end
    if (issue) begin
      state_d      = ACCESS;
      req_d.addr   = {req_addr[AW-1:2], 2'b00};
      req_d.wdata  = wrep;
      req_d.sel    = sel;
      req_d.funct3 = req_funct3;
      req_d.off    = off;
      req_d.wen    = req_is_store;
      req_d.ren    = !req_is_store;
    end

    ld_valid_d = complete && req_q.ren;
    shifted    = mmu_dataout >> {req_q.off, 3'b000};
    ld_data_d  = ld_data_q;
    if (ld_valid_d) begin
      case (req_q.funct3)
        3'b000:  ld_data_d = {{24{shifted[7]}}, shifted[7:0]};
        3'b001:  ld_data_d = {{16{shifted[15]}}, shifted[15:0]};
        3'b100:  ld_data_d = {24'h0, shifted[7:0]};
        3'b101:  ld_data_d = {16'h0, shifted[15:0]};
        default: ld_data_d = shifted;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
`endif
    end
  end

  assign pipe_stall   = (state_q == ACCESS) && !mmu_nostall;
  assign ld_valid     = ld_valid_q;
  assign ld_data      = ld_data_q;
  assign mmu_addy     = req_q.addr;
  assign mmu_datain   = req_q.wdata;
  assign mmu_wen      = req_q.wen;
  assign mmu_ren      = req_q.ren;
  assign mmu_byte_sel = req_q.sel;

endmodule

// File: tb/tb_load_store_unit_d.sv
// Bench for load_store_unit_d: table of single accesses plus stall, back-to-back and reset sequences.
module tb_load_store_unit_d;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_is_store, mmu_nostall;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mmu_dataout;
  logic        pipe_stall, ld_valid, mmu_wen, mmu_ren;
  logic [31:0] ld_data, mmu_addy, mmu_datain;
  logic [3:0]  mmu_byte_sel;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
  logic [31:0] misalign_addr;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  load_store_unit_d dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .pipe_stall(pipe_stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .mmu_addy(mmu_addy), .mmu_datain(mmu_datain), .mmu_wen(mmu_wen), .mmu_ren(mmu_ren),
    .mmu_byte_sel(mmu_byte_sel), .mmu_nostall(mmu_nostall), .mmu_dataout(mmu_dataout)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign), .misalign_addr(misalign_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load results are checked against the scoreboard whenever the DUT pulses ld_valid.
  always @(negedge clk) begin
    if (!reset && ld_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ld_valid: got ld_data %h expected no load", ld_data);
      end else begin
        chk("ld_data", ld_data, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic        acc;
    logic [3:0]  sel;
    logic [31:0] addy;
    logic [31:0] datain;
    logic [31:0] ld;
    logic        mis;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = w;
  endtask

  initial begin
    vec_t v;
    logic exp_acc;
    vt[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b1, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1'b1, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80, 1'b0};
    vt[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 1'b1, 4'b1000, 32'h100, 32'h0,        32'h00000080, 1'b0};
    vt[3]  = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1'b1, 4'b1100, 32'h100, 32'hABCDABCD, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 3'b001, 32'h101, 32'h0,        32'h0000F123, 1'b1, 4'b0011, 32'h100, 32'h0,        32'hFFFFF123, 1'b1};
    vt[5]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80010000, 1'b1, 4'b1100, 32'h100, 32'h0,        32'h00008001, 1'b0};
    vt[6]  = '{1'b1, 3'b000, 32'h205, 32'h0000005A, 32'h0,        1'b1, 4'b0010, 32'h204, 32'h5A5A5A5A, 32'h0,        1'b0};
    vt[7]  = '{1'b1, 3'b010, 32'h30C, 32'hCAFEF00D, 32'h0,        1'b1, 4'b1111, 32'h30C, 32'hCAFEF00D, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 3'b011, 32'h10,  32'h0,        32'h12345678, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b0};
    vt[9]  = '{1'b1, 3'b100, 32'h10,  32'h11111111, 32'h0,        1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b0};
    vt[10] = '{1'b0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 1'b1, 4'b0010, 32'h0,   32'h0,        32'h0000007F, 1'b0};
    vt[11] = '{1'b0, 3'b010, 32'h107, 32'h0,        32'h01234567, 1'b1, 4'b1111, 32'h104, 32'h0,        32'h01234567, 1'b1};
    vt[12] = '{1'b0, 3'b110, 32'h20,  32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b0};
    vt[13] = '{1'b1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0,        1'b1, 4'b1100, 32'h100, 32'hBEEFBEEF, 32'h0,        1'b1};

    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mmu_nostall = 1'b1; mmu_dataout = '0;
    repeat (2) @(negedge clk);
    chk("rst_pipe_stall", pipe_stall, 0);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_mmu_addy", mmu_addy, 0);
    chk("rst_mmu_datain", mmu_datain, 0);
    chk("rst_mmu_wen", mmu_wen, 0);
    chk("rst_mmu_ren", mmu_ren, 0);
    chk("rst_byte_sel", mmu_byte_sel, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      exp_acc = v.acc && !(TRAP && v.mis);
      @(negedge clk);
      chk("idle_ren", mmu_ren, 0);
      chk("idle_wen", mmu_wen, 0);
      drive(v.st, v.f3, v.addr, v.wdata);
      mmu_dataout = v.dout;
      if (exp_acc && !v.st) sb.push_back(v.ld);
      @(negedge clk);
      req_valid = 1'b0;
      chk("vec_pipe_stall", pipe_stall, 0);
      chk("vec_wen", mmu_wen, exp_acc && v.st);
      chk("vec_ren", mmu_ren, exp_acc && !v.st);
      if (exp_acc) begin
        chk("vec_byte_sel", mmu_byte_sel, v.sel);
        chk("vec_addy", mmu_addy, v.addy);
        if (v.st) chk("vec_datain", mmu_datain, v.datain);
      end
`ifdef MISALIGN_TRAP_EN
      chk("vec_misalign", misalign, v.mis && v.acc);
      if (v.mis && v.acc) chk("vec_misalign_addr", misalign_addr, v.addr);
`endif
    end

    // LW held by a 5-cycle miss, with a SW waiting behind it.
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h100, 32'h0);
    mmu_nostall = 1'b0;
    mmu_dataout = 32'hBADBADBA;
    sb.push_back(32'h11223344);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h40, 32'hA5A5A5A5);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("stall_pipe_stall", pipe_stall, 1);
      chk("stall_addy", mmu_addy, 32'h100);
      chk("stall_ren", mmu_ren, 1);
      chk("stall_wen", mmu_wen, 0);
      chk("stall_byte_sel", mmu_byte_sel, 4'b1111);
      chk("stall_ld_valid", ld_valid, 0);
    end
    mmu_nostall = 1'b1;
    mmu_dataout = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_wen", mmu_wen, 1);
    chk("b2b_ren", mmu_ren, 0);
    chk("b2b_addy", mmu_addy, 32'h40);
    chk("b2b_datain", mmu_datain, 32'hA5A5A5A5);
    chk("b2b_pipe_stall", pipe_stall, 0);
    @(negedge clk);
    chk("b2b_ld_valid_pulse", ld_valid, 0);
    chk("b2b_wen_done", mmu_wen, 0);

    // Reset while stalled, then reset held against a valid request.
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h200, 32'h0);
    mmu_nostall = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_pipe_stall", pipe_stall, 1);
    chk("pre_rst_ren", mmu_ren, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pipe_stall", pipe_stall, 0);
    chk("mid_rst_ren", mmu_ren, 0);
    chk("mid_rst_addy", mmu_addy, 0);
    chk("mid_rst_byte_sel", mmu_byte_sel, 0);
    chk("mid_rst_ld_valid", ld_valid, 0);
    drive(1'b0, 3'b010, 32'h300, 32'h0);
    mmu_nostall = 1'b1;
    @(negedge clk);
    chk("rst_wins_ren", mmu_ren, 0);
    chk("rst_wins_addy", mmu_addy, 0);
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_sb_empty", sb.size(), 0);

    // Recovery after reset.
    drive(1'b0, 3'b001, 32'h106, 32'h0);
    mmu_dataout = 32'h7ABC0000;
    sb.push_back(32'h00007ABC);
    @(negedge clk);
    req_valid = 1'b0;
    chk("recover_byte_sel", mmu_byte_sel, 4'b1100);
    chk("recover_addy", mmu_addy, 32'h104);
    repeat (2) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
